imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction ROM (registered read, 1-cycle latency,
//  word-indexed by address[NADDR_BITS-1:2]) between two requesters: CPU fetch (port 0)
//  and debug/loader readback (port 1). Per-port valid/ready handshakes, arbitration,
//  a stable held ROM address, and response routing with backpressure. Sits between the
//  core fetch stage / debug unit and the ROM instance.
// PARAMETERS
//  NADDR_BITS  8  byte-address width; must match the ROM
//  ARB_MODE    0  0 = round-robin; 1 = fixed priority, port 0 always wins
// PORTS
//  clock        in   1           single clock; all state updates on posedge
//  reset_n      in   1           synchronous, active-low reset
//  req_valid    in   2           per-port request valid; bit0 fetch, bit1 debug
//  req_addr0    in   NADDR_BITS  port-0 byte address
//  req_addr1    in   NADDR_BITS  port-1 byte address
//  req_ready    out  2           per-port accept; one-hot or zero
//  rsp_valid    out  2           per-port response valid; one-hot or zero
//  rsp_ready    in   2           per-port response accept
//  rsp_data     out  32          instruction word; mem_q when any rsp_valid, else 0
//  rsp_err      out  1           misaligned request (addr[1:0]!=0); valid with rsp_valid
//  mem_address  out  NADDR_BITS  to ROM address; registered, held stable
//  mem_q        in   32          from ROM q
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0,
//   mem_address=0, grant=0, last_grant=1 (port 0 wins first tie). Aborts any access in
//   flight; no response for it is ever produced.
//  FSM:
//   IDLE: winner = arbitration over req_valid; req_ready[winner]=1 combinationally.
//     Handshake (valid&ready) at cycle T: load mem_address<=winner addr, grant<=winner,
//     err<=|addr[1:0], last_grant<=winner; go ISSUE. No request: stay IDLE.
//   ISSUE (T+1): ROM samples mem_address; req_ready=0; go RESP.
//   RESP (T+2 on): rsp_valid[grant]=1, rsp_data=mem_q, rsp_err=err. Hold until
//     rsp_ready[grant]=1, then go IDLE. rsp_ready of the non-granted port is ignored.
//  Latency: request handshake at T -> rsp_valid at T+2. Min 3 cycles per transaction;
//   next handshake no earlier than the cycle after the response handshake.
//  Arbitration, ARB_MODE=0: single requester wins; both valid -> port != last_grant.
//   ARB_MODE=1: port 0 wins whenever req_valid[0]=1.
//  req_ready is 0 outside IDLE; a requester holds valid/addr stable until accepted.
//   Dropping valid before acceptance is allowed and cancels nothing (never accepted).
//  mem_address changes only on a handshake, so mem_q stays stable while in RESP under
//   any backpressure duration.
//  Misaligned address: ROM still read at word addr[NADDR_BITS-1:2]; data returned with
//   rsp_err=1; requester decides. Top address (all ones) is legal; no wrap handling.
//  rsp_valid, rsp_err and rsp_data are 0 whenever not in RESP.
// TESTING
//  1 Port0 only, addr 0x04, rsp_ready=1 -> req_ready[0] at T, rsp_valid=01 at T+2,
//    rsp_data=ROM word 1, rsp_err=0, back to IDLE at T+3.
//  2 Both valid continuously, ARB_MODE=0 -> grants 0,1,0,1 after reset; ARB_MODE=1 ->
//    grants 0,0,0,0; port1 never ready while port0 valid.
//  3 Port1 addr 0x08, rsp_ready[1]=0 for 5 cycles -> rsp_valid=10 held 5+ cycles,
//    rsp_data and mem_address=0x08 constant; port0 request stalls with req_ready=0.
//  4 Port0 addr 0x06 -> rsp_err=1 with rsp_data=ROM word 1.
//  5 reset_n=0 in ISSUE and in RESP -> next cycle all outputs 0, IDLE; no stale
//    rsp_valid afterwards; first tie after reset grants port 0.
//  6 rsp_ready on the wrong port during RESP -> ignored, response remains pending.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one registered-read instruction ROM between fetch (port 0)
// and debug readback (port 1). Ports: clock, reset_n, req_*, rsp_*, mem_address, mem_q.
module imem_arbiter #(
  parameter int NADDR_BITS = 8,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  input  logic [NADDR_BITS-1:0] req_addr0,
  input  logic [NADDR_BITS-1:0] req_addr1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [NADDR_BITS-1:0] mem_address,
  input  logic [31:0]           mem_q
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam bit RR = (ARB_MODE == 0);

  state_t                state;
  state_t                state_nx;
  logic                  grant;
  logic                  last_grant;
  logic                  err;
  logic                  win;
  logic                  any_req;
  logic                  hs;
  logic [NADDR_BITS-1:0] win_addr;

  // Both requesting: round-robin alternates, fixed mode keeps port 0.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b10)
      win = 1'b1;
    else if (req_valid == 2'b11 && RR)
      win = ~last_grant;
  end

  assign win_addr = win ? req_addr1 : req_addr0;
  assign any_req  = |req_valid;
  assign hs       = (state == IDLE) && any_req;

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[win] = 1'b1;
          state_nx       = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid[grant] = 1'b1;
        rsp_data         = mem_q;
        rsp_err          = err;
        if (rsp_ready[grant])
          state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // mem_address only moves on a request handshake, so mem_q
  // stays stable for however long the response is backpressured.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_address <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      err         <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        mem_address <= win_addr;
        grant       <= win;
        last_grant  <= win;
        err         <= |win_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scoreboard bench for imem_arbiter.
// Round-robin DUT fully checked; fixed-priority DUT checked on arbitration.
module tb_imem_arbiter;

  typedef struct {
    logic        p;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [7:0]  req_addr0 = 8'h00;
  logic [7:0]  req_addr1 = 8'h00;
  logic [1:0]  rsp_ready = 2'b00;

  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  mem_address;
  logic [31:0] mem_q;

  logic [1:0]  req_ready1;
  logic [1:0]  rsp_valid1;
  logic [31:0] rsp_data1;
  logic        rsp_err1;
  logic [7:0]  mem_address1;
  logic [31:0] mem_q1;

  logic [31:0] rom [64];

  exp_t sb[$];
  logic gl0[$];
  logic gl1[$];
  exp_t mon_e;
  logic mon_p;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imem_arbiter #(.NADDR_BITS(8), .ARB_MODE(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_q(mem_q)
  );

  imem_arbiter #(.NADDR_BITS(8), .ARB_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .rsp_err(rsp_err1), .mem_address(mem_address1),
    .mem_q(mem_q1)
  );

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = 32'hC0DE_0000 | i;
  end

  always @(posedge clock) begin
    mem_q  <= rom[mem_address[7:2]];
    mem_q1 <= rom[mem_address1[7:2]];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic p,
                      input logic [31:0] d,
                      input logic e);
    exp_t x;
    x.p = p;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clock) begin
    if (reset_n) begin
      if (rsp_valid == 2'b00) begin
        chk("idle_data", rsp_data, 32'h0);
        chk("idle_err", {31'h0, rsp_err}, 32'h0);
      end else if (sb.size() == 0) begin
        chk("stale_rsp", {30'h0, rsp_valid}, 32'h0);
      end else begin
        mon_p = rsp_valid[1];
        chk("rsp_port", {30'h0, rsp_valid},
            sb[0].p ? 32'h2 : 32'h1);
        if (rsp_ready[mon_p]) begin
          mon_e = sb.pop_front();
          chk("rsp_data", rsp_data, mon_e.d);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.e});
          gl0.push_back(mon_p);
        end
      end
      if ((rsp_valid1 & rsp_ready) != 2'b00)
        gl1.push_back(rsp_valid1[1]);
    end
  end

  // Returns at the negedge where port p is accepted.
  task automatic wait_ready(input logic p,
                            input logic [31:0] d,
                            input logic e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready[p]) begin
        push(p, d, e);
        return;
      end
      @(posedge clock); #1;
    end
    chk("req_timeout", {31'h0, req_ready[p]}, 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) begin
        @(posedge clock); #1;
        return;
      end
      @(negedge clock);
    end
    chk("drain_timeout", sb.size(), 32'h0);
    sb.delete();
    @(posedge clock); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_ready"}, {30'h0, req_ready}, 32'h0);
    chk({nm, "_rsp_valid"}, {30'h0, rsp_valid}, 32'h0);
    chk({nm, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({nm, "_rsp_data"}, rsp_data, 32'h0);
    chk({nm, "_mem_addr"}, {24'h0, mem_address}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: single fetch, latency and return to IDLE
    req_addr0 = 8'h04;
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clock);
    chk("t1_ready_T", {30'h0, req_ready}, 32'h1);
    push(1'b0, 32'hC0DE_0001, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    chk("t1_valid_T1", {30'h0, rsp_valid}, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t1_valid_T2", {30'h0, rsp_valid}, 32'h1);
    @(posedge clock); #1;
    req_addr0 = 8'hFC;
    req_valid = 2'b01;
    @(negedge clock);
    chk("t1_idle_T3", {30'h0, rsp_valid}, 32'h0);
    chk("t1_ready_T3", {30'h0, req_ready}, 32'h1);
    push(1'b0, 32'hC0DE_003F, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    drain();

    // 4: misaligned
    req_addr0 = 8'h06;
    req_valid = 2'b01;
    wait_ready(1'b0, 32'hC0DE_0001, 1'b1);
    @(posedge clock); #1;
    req_valid = 2'b00;
    drain();

    // 3 + 6: backpressure with wrong-port ready, port 0 stalls
    rsp_ready = 2'b01;
    req_addr1 = 8'h08;
    req_valid = 2'b10;
    wait_ready(1'b1, 32'hC0DE_0002, 1'b0);
    @(posedge clock); #1;
    req_addr0 = 8'h10;
    req_valid = 2'b01;
    @(negedge clock);
    chk("t3_issue_ready", {30'h0, req_ready}, 32'h0);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t3_hold_valid", {30'h0, rsp_valid}, 32'h2);
      chk("t3_hold_data", rsp_data, 32'hC0DE_0002);
      chk("t3_hold_addr", {24'h0, mem_address}, 32'h08);
      chk("t3_stall_ready", {30'h0, req_ready}, 32'h0);
      @(posedge clock); #1;
    end
    rsp_ready = 2'b11;
    wait_ready(1'b0, 32'hC0DE_0004, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    drain();

    // 5a: reset during ISSUE
    req_addr0 = 8'h04;
    req_valid = 2'b01;
    wait_ready(1'b0, 32'hC0DE_0001, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk_zero("t5_issue");
    sb.delete();
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("t5a_no_stale", {30'h0, rsp_valid}, 32'h0);
    end
    @(posedge clock); #1;

    // 5b: reset during RESP, then first tie goes to port 0
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    wait_ready(1'b0, 32'hC0DE_0001, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(posedge clock); #1;
    @(negedge clock);
    chk("t5_in_resp", {30'h0, rsp_valid}, 32'h1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk_zero("t5_resp");
    sb.delete();
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("t5b_no_stale", {30'h0, rsp_valid}, 32'h0);
    end
    @(posedge clock); #1;
    req_addr0 = 8'h00;
    req_addr1 = 8'h0C;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    @(negedge clock);
    chk("t5_tie_p0", {30'h0, req_ready}, 32'h1);
    push(1'b0, 32'hC0DE_0000, 1'b0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    drain();

    // 2: continuous contention in both arbitration modes
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    sb.delete();
    gl0.delete();
    gl1.delete();
    req_addr0 = 8'h00;
    req_addr1 = 8'h0C;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (req_ready[0]) push(1'b0, 32'hC0DE_0000, 1'b0);
      if (req_ready[1]) push(1'b1, 32'hC0DE_0003, 1'b0);
      chk("t2_fixed_p1_blocked",
          {31'h0, req_ready1[1]}, 32'h0);
      @(posedge clock); #1;
    end
    req_valid = 2'b00;
    drain();
    chk("t2_rr_count", gl0.size(), 32'd4);
    chk("t2_fixed_count", gl1.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gl0.size())
        chk("t2_rr_grant", {31'h0, gl0[k]}, k % 2);
      if (k < gl1.size())
        chk("t2_fixed_grant", {31'h0, gl1[k]}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
